// File: rtl/segre_pkg.sv
// Shared types and constants for the Segre core front end.
// Holds the fetch-stage state encoding, boot address and fetch-queue entry layout.
package segre_pkg;

    localparam int WORD_SIZE = 32;

    localparam logic [WORD_SIZE-1:0] IF_BOOT_ADDR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_RESET,
        IF_FETCH,
        IF_DRAIN
    } if_state_e;

    typedef struct packed {
        logic [WORD_SIZE-1:0] instr;
        logic [WORD_SIZE-1:0] pc;
    } fetch_entry_t;

    // Word-align a fetch target by clearing the byte offset.
    function automatic logic [WORD_SIZE-1:0] if_align_pc(input logic [WORD_SIZE-1:0] pc);
        return pc & ~WORD_SIZE'(3);
    endfunction

endpackage

// File: rtl/segre_fetch_queue.sv
// Synchronous FIFO with flush, used for fetched words and for in-flight request addresses.
// DEPTH must be a power of two so the pointers wrap without extra logic.
module segre_fetch_queue
    import segre_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  entry_t                 data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output entry_t                 data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               do_push;
    logic               do_pop;

    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_COUNT) || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_COUNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/segre_if_stage.sv
// Segre instruction-fetch stage: PC, credit-limited memory requests, fetch queue to decode.
// Optional SEGRE_IF_MISALIGN_CHECK_EN adds a sticky fetch_misaligned_o and blocks misaligned targets.
module segre_if_stage
    import segre_pkg::*;
#(
    parameter logic [WORD_SIZE-1:0] BOOT_ADDR   = IF_BOOT_ADDR,
    parameter int                   QUEUE_DEPTH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 hazard_i,
    input  logic                 redirect_i,
    input  logic [WORD_SIZE-1:0] redirect_pc_i,
    output logic                 mem_req_o,
    output logic [WORD_SIZE-1:0] mem_addr_o,
    input  logic                 mem_gnt_i,
    input  logic                 mem_rvalid_i,
    input  logic [WORD_SIZE-1:0] mem_rdata_i,
    output logic [WORD_SIZE-1:0] instr_o,
    output logic [WORD_SIZE-1:0] pc_o,
    output logic                 instr_valid_o
`ifdef SEGRE_IF_MISALIGN_CHECK_EN
    ,
    output logic                 fetch_misaligned_o
`endif
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CNT_W:0] CREDIT_LIMIT = (CNT_W + 1)'(QUEUE_DEPTH);

    if_state_e            state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [WORD_SIZE-1:0] target_pc;
    logic                 fetch_blocked;

    fetch_entry_t         q_push_data;
    fetch_entry_t         q_head;
    logic                 q_push, q_pop, q_flush, q_full, q_empty;
    logic [CNT_W-1:0]     q_count;

    logic [WORD_SIZE-1:0] addr_head;
    logic                 a_pop, a_full, a_empty;
    logic [CNT_W-1:0]     outstanding;

    logic                 fetching;
    logic                 grant;
    logic                 consume;
    logic [CNT_W:0]       credit_used;

    assign fetching = (state_q == IF_FETCH);

`ifdef SEGRE_IF_MISALIGN_CHECK_EN
    logic misaligned_q;

    assign target_pc          = redirect_pc_i;
    assign fetch_blocked      = misaligned_q;
    assign fetch_misaligned_o = misaligned_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            misaligned_q <= 1'b0;
        end else if (redirect_i && (state_q != IF_RESET) && (redirect_pc_i[1:0] != 2'b00)) begin
            misaligned_q <= 1'b1;
        end
    end
`else
    assign target_pc     = if_align_pc(redirect_pc_i);
    assign fetch_blocked = 1'b0;
`endif

    // Decode handshake: the head is offered only while fetching on the live path.
    assign instr_valid_o = fetching && !q_empty;
    assign consume       = instr_valid_o && !hazard_i;

    // Credits count the slot freed by this cycle's dequeue, so a 1-cycle memory sustains one word per cycle.
    assign credit_used = (CNT_W + 1)'(outstanding) + (CNT_W + 1)'(q_count) - (CNT_W + 1)'(consume);
    assign mem_req_o   = fetching && !fetch_blocked && !a_full && (credit_used < CREDIT_LIMIT);
    assign mem_addr_o  = (state_q == IF_RESET) ? '0 : pc_q;
    assign grant       = mem_req_o && mem_gnt_i;

    assign a_pop = mem_rvalid_i && !a_empty;

    // Responses during a redirect cycle or while draining belong to the abandoned path.
    assign q_push      = fetching && a_pop && !redirect_i && (!q_full || q_pop);
    assign q_pop       = consume && !redirect_i;
    assign q_flush     = redirect_i && (state_q != IF_RESET);
    assign q_push_data = '{instr: mem_rdata_i, pc: addr_head};

    segre_fetch_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_data_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (q_push),
        .data_i  (q_push_data),
        .pop_i   (q_pop),
        .flush_i (q_flush),
        .data_o  (q_head),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );

    // Address FIFO is never flushed: its occupancy is the outstanding-request count.
    segre_fetch_queue #(
        .DEPTH   (QUEUE_DEPTH),
        .entry_t (logic [WORD_SIZE-1:0])
    ) u_addr_queue (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .data_i  (pc_q),
        .pop_i   (a_pop),
        .flush_i (1'b0),
        .data_o  (addr_head),
        .full_o  (a_full),
        .empty_o (a_empty),
        .count_o (outstanding)
    );

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IF_RESET: begin
                pc_d    = BOOT_ADDR;
                state_d = IF_FETCH;
            end
            IF_FETCH: begin
                if (redirect_i) begin
                    pc_d = target_pc;
                    if ((outstanding != '0) || grant) state_d = IF_DRAIN;
                end else if (grant) begin
                    pc_d = pc_q + WORD_SIZE'(4);
                end
            end
            IF_DRAIN: begin
                if (redirect_i) begin
                    pc_d = target_pc;
                end else if ((outstanding == '0) ||
                             ((outstanding == CNT_W'(1)) && mem_rvalid_i)) begin
                    state_d = IF_FETCH;
                end
            end
            default: begin
                state_d = IF_RESET;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IF_RESET;
            pc_q    <= BOOT_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign instr_o = instr_valid_o ? q_head.instr : '0;
    assign pc_o    = instr_valid_o ? q_head.pc    : '0;

endmodule
